// File: rtl/param_bus_cpu.sv
// param_bus_cpu: parametrised multi-cycle bus CPU.
// FETCH -> DECODE -> (EXEC -> WB) -> FETCH, with HALT as an absorbing state.
// Internal bus is a mux that reads zero when nothing drives it.
// Optional feature macro: CPU_MUL_EN (op B becomes an unsigned multiply on the ALU path).
module param_bus_cpu #(
  parameter int  DATA_W  = 16,
  parameter int  NREGS   = 8,
  parameter int  PC_W    = 6,
  localparam int RSEL_W  = $clog2(NREGS),
  localparam int INSTR_W = 4 + 2*RSEL_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  bus_out,
  output logic               done,
  output logic               halted,
  output logic               flag_z,
  output logic               flag_c
);

  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_LDD  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_BZ   = 4'h7;
  localparam logic [3:0] OP_B    = 4'h8;
  localparam logic [3:0] OP_BL   = 4'h9;
  localparam logic [3:0] OP_BX   = 4'hA;
`ifdef CPU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'hB;
`endif
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED} state_t;

  state_t                         state_q, state_d;
  logic [PC_W-1:0]                pc_q, pc_d;
  logic [INSTR_W-1:0]             ir_q, ir_d;
  logic [DATA_W-1:0]              a_q, a_d, g_q, g_d;
  logic [NREGS-1:0][DATA_W-1:0]   regs_q, regs_d;
  logic                           done_q, done_d, halted_q, halted_d;
  logic                           z_q, z_d, c_q, c_d;
  logic [DATA_W-1:0]              bus;

  logic [3:0]        op;
  logic [RSEL_W-1:0] rx, ry;
  logic [DATA_W-1:0] rx_val, ry_val, alu_res;
  logic [PC_W-1:0]   br_addr;
  logic [DATA_W:0]   sum, diff;
  logic              is_alu;

  assign op      = ir_q[INSTR_W-1 -: 4];
  assign rx      = ir_q[2*RSEL_W-1 -: RSEL_W];
  assign ry      = ir_q[RSEL_W-1:0];
  assign rx_val  = regs_q[rx];
  assign ry_val  = regs_q[ry];
  assign br_addr = PC_W'({rx, ry});
  // Extra top bit carries out (ADD) or borrows (SUB).
  assign sum     = {1'b0, a_q} + {1'b0, ry_val};
  assign diff    = {1'b0, a_q} - {1'b0, ry_val};

  // Classify ops that take the EXEC/WB path.
  always_comb begin
    is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) || (op == OP_AND);
`ifdef CPU_MUL_EN
    if (op == OP_MUL) is_alu = 1'b1;
`endif
  end

  // ALU result from the A latch and R[ry].
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = sum[DATA_W-1:0];
      OP_SUB:  alu_res = diff[DATA_W-1:0];
      OP_XOR:  alu_res = a_q ^ ry_val;
      OP_AND:  alu_res = a_q & ry_val;
`ifdef CPU_MUL_EN
      OP_MUL:  alu_res = a_q * ry_val;
`endif
      default: alu_res = '0;
    endcase
  end

  // Next-state, datapath writes and bus mux; at most one register write per cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    g_d      = g_q;
    regs_d   = regs_q;
    done_d   = 1'b0;
    halted_d = halted_q;
    z_d      = z_q;
    c_d      = c_q;
    bus      = '0;
    case (state_q)
      S_FETCH: begin
        ir_d    = imem_data;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        done_d  = 1'b1;
        if (is_alu) begin
          bus     = rx_val;
          a_d     = rx_val;
          state_d = S_EXEC;
          done_d  = 1'b0;
        end else begin
          case (op)
            OP_MOV: begin bus = ry_val;  regs_d[rx] = ry_val;  end
            OP_LDD: begin bus = data_in; regs_d[rx] = data_in; end
            OP_BZ:  if (z_q) pc_d = br_addr;
            OP_B:   pc_d = br_addr;
            OP_BL: begin
              // pc_q already points past the BL, which is the return address.
              bus               = DATA_W'(pc_q);
              regs_d[NREGS-1]   = DATA_W'(pc_q);
              pc_d              = br_addr;
            end
            OP_BX: begin bus = rx_val; pc_d = PC_W'(rx_val); end
            OP_HALT: begin
              state_d  = S_HALTED;
              halted_d = 1'b1;
              done_d   = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_EXEC: begin
        bus     = ry_val;
        g_d     = alu_res;
        z_d     = (alu_res == '0);
        if (op == OP_ADD) c_d = sum[DATA_W];
        if (op == OP_SUB) c_d = diff[DATA_W];
        state_d = S_WB;
      end
      S_WB: begin
        bus        = g_q;
        regs_d[rx] = g_q;
        done_d     = 1'b1;
        state_d    = S_FETCH;
      end
      default: ;
    endcase
  end

  // State registers; synchronous active-low reset discards any instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      g_q      <= '0;
      regs_q   <= '0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      g_q      <= g_d;
      regs_q   <= regs_d;
      done_q   <= done_d;
      halted_q <= halted_d;
      z_q      <= z_d;
      c_q      <= c_d;
    end
  end

  assign imem_addr = pc_q;
  assign bus_out   = bus;
  assign done      = done_q;
  assign halted    = halted_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;

endmodule

// File: tb/tb_param_bus_cpu.sv
// Bench for param_bus_cpu: instruction-level model predicts every cycle's outputs.
module tb_param_bus_cpu;
  localparam int DW = 16, NR = 8, PW = 6, IW = 10;

  logic          clk = 1'b0, rst = 1'b0;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic [DW-1:0] data_in = '0, bus_out;
  logic          done, halted, flag_z, flag_c;
  logic [IW-1:0] mem [64];

  assign imem_data = mem[imem_addr];
  always #5 clk = ~clk;

  param_bus_cpu dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .data_in(data_in), .bus_out(bus_out), .done(done), .halted(halted),
    .flag_z(flag_z), .flag_c(flag_c)
  );

  int n_tests = 0, n_fail = 0;
  int unsigned m_pc, m_r[NR];
  bit m_z, m_c, m_done;
  logic [31:0] last_dec_bus, last_wb_bus;

  function automatic logic [IW-1:0] enc(input int op, input int rx, input int ry);
    return {op[3:0], rx[2:0], ry[2:0]};
  endfunction

  function automatic bit is_alu(input int op);
`ifdef CPU_MUL_EN
    if (op == 11) return 1'b1;
`endif
    return (op >= 3 && op <= 6);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_cyc(input string nm, input int unsigned addr, input int unsigned bus,
                         input bit dn, input bit hl);
    chk({nm, "_addr"},   32'(imem_addr), addr);
    chk({nm, "_bus"},    32'(bus_out), bus);
    chk({nm, "_done"},   32'(done), 32'(dn));
    chk({nm, "_halted"}, 32'(halted), 32'(hl));
    chk({nm, "_zc"},     32'({flag_z, flag_c}), 32'({m_z, m_c}));
  endtask

  task automatic model_reset();
    m_pc = 0; m_z = 0; m_c = 0; m_done = 0;
    for (int i = 0; i < NR; i++) m_r[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    model_reset();
    chk_cyc("reset", 0, 0, 0, 0);
    rst = 1'b1;
  endtask

  // Runs one instruction; called at the negedge of its FETCH cycle.
  task automatic step(input logic [DW-1:0] d, input bit abort_exec = 1'b0);
    logic [IW-1:0] ins;
    int unsigned op, rx, ry, a, b, res, nxt, dbus, addr;
    ins  = mem[m_pc];
    op   = ins[9:6]; rx = ins[5:3]; ry = ins[2:0];
    nxt  = (m_pc + 1) % 64;
    addr = (rx * 8 + ry) % 64;
    data_in = d;
    chk_cyc("fetch", m_pc, 0, m_done, 0);
    @(negedge clk);
    dbus = 0;
    if (is_alu(op)) dbus = m_r[rx];
    else case (op)
      1: dbus = m_r[ry];
      2: dbus = d;
      9: dbus = nxt;
      10: dbus = m_r[rx];
      default: dbus = 0;
    endcase
    chk_cyc("decode", nxt, dbus, 0, 0);
    last_dec_bus = 32'(bus_out);
    @(negedge clk);
    if (op == 15) begin
      m_pc = nxt;
      return;
    end
    if (is_alu(op)) begin
      a = m_r[rx]; b = m_r[ry];
      chk_cyc("exec", nxt, b, 0, 0);
      if (abort_exec) begin
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        return;
      end
      @(negedge clk);
      case (op)
        3: begin res = (a + b) & 32'hFFFF; m_c = (a + b) > 32'hFFFF; end
        4: begin res = (a - b) & 32'hFFFF; m_c = a < b; end
        5: res = a ^ b;
        6: res = a & b;
        default: res = (a * b) & 32'hFFFF;
      endcase
      m_z = (res == 0);
      chk_cyc("wb", nxt, res, 0, 0);
      last_wb_bus = 32'(bus_out);
      m_r[rx] = res;
      m_pc = nxt;
      @(negedge clk);
    end else begin
      m_pc = nxt;
      case (op)
        1: m_r[rx] = m_r[ry];
        2: m_r[rx] = d;
        7: if (m_z) m_pc = addr;
        8: m_pc = addr;
        9: begin m_r[NR-1] = nxt; m_pc = addr; end
        10: m_pc = m_r[rx] % 64;
        default: ;
      endcase
    end
    m_done = 1;
  endtask

  task automatic halt_check(input int n);
    for (int i = 0; i < n; i++) begin
      chk_cyc("halt", m_pc, 0, 0, 1);
      @(negedge clk);
    end
  endtask

  initial begin
    // Directed program: arithmetic, flags, conditional branches, HALT.
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = enc(2, 1, 0);  mem[1] = enc(2, 2, 0);  mem[2] = enc(3, 1, 2);
    mem[3] = enc(2, 3, 0);  mem[4] = enc(2, 4, 0);  mem[5] = enc(3, 3, 4);
    mem[6] = enc(4, 4, 3);  mem[7] = enc(4, 1, 1);  mem[8] = enc(7, 4, 0);
    mem[32] = enc(3, 4, 4); mem[33] = enc(7, 0, 0); mem[34] = enc(15, 0, 0);
    do_reset();
    step(16'h0005); step(16'h000A); step(16'h0);
    chk("t2_wb", last_wb_bus, 32'h000F);
    chk("t2_zc", 32'({flag_z, flag_c}), 32'b00);
    step(16'hFFFF); step(16'h0001); step(16'h0);
    chk("t3_add_wb", last_wb_bus, 32'h0);
    chk("t3_add_zc", 32'({flag_z, flag_c}), 32'b11);
    step(16'h0);
    chk("t3_sub_wb", last_wb_bus, 32'h1);
    chk("t3_sub_zc", 32'({flag_z, flag_c}), 32'b00);
    step(16'h0);
    chk("t4_sub_z", 32'(flag_z), 32'h1);
    step(16'h0);
    chk("t4_bz_taken", 32'(imem_addr), 32'h20);
    step(16'h0); step(16'h0);
    chk("t4_bz_fall", 32'(imem_addr), 32'h22);
    step(16'h0);
    halt_check(10);
    chk("t6_halt_addr", 32'(imem_addr), 32'h23);

    // Link/return and PC wrap.
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = enc(8, 0, 5); mem[5] = enc(9, 2, 0); mem[16] = enc(10, 7, 0);
    mem[6] = enc(8, 7, 7); mem[63] = enc(0, 0, 0);
    do_reset();
    step(16'h0); step(16'h0);
    chk("t5_link", last_dec_bus, 32'h6);
    chk("t5_bl_pc", 32'(imem_addr), 32'h10);
    step(16'h0);
    chk("t5_bx_pc", 32'(imem_addr), 32'h6);
    step(16'h0); step(16'h0);
    chk("t5_wrap", 32'(imem_addr), 32'h0);

    // Reset landing in the middle of an ALU op must leave no writeback.
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = enc(2, 1, 0); mem[1] = enc(3, 1, 1);
    do_reset();
    step(16'h1234);
    step(16'h0, 1'b1);
    chk_cyc("abort", 0, 0, 0, 0);
    mem[0] = enc(1, 5, 1);
    rst = 1'b1;
    step(16'h0);
    chk("t6_abort_r1", last_dec_bus, 32'h0);

    // Random programs without HALT.
    for (int i = 0; i < 64; i++)
      mem[i] = enc($urandom_range(0, 14), $urandom_range(0, 7), $urandom_range(0, 7));
    do_reset();
    for (int i = 0; i < 400; i++) step(16'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
